reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp_pkg.sv | 8 +
 rtl/reg_file_mp_scoreboard.sv | 36 +++
 rtl/reg_file_mp.sv | 84 ++++++++
 tb/tb_reg_file_mp.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared RISC-V core defaults: register file geometry and the register address type.
package riscv_defines;
  localparam int RF_WORD_WIDTH = 32;
  localparam int RF_N_REGS     = 32;
  localparam int RF_ADDR_WIDTH = $clog2(RF_N_REGS);

  typedef logic [RF_ADDR_WIDTH-1:0] reg_addr_t;
endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Busy-bit tracker for long-latency writes: flush > reserve > clear, x0 never busy.
module reg_scoreboard
  import riscv_defines::*;
#(
  parameter  int N_REGS     = RF_N_REGS,
  localparam int ADDR_WIDTH = $clog2(N_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en_i,
  input  logic [ADDR_WIDTH-1:0] set_addr_i,
  input  logic                  clr_en_i,
  input  logic [ADDR_WIDTH-1:0] clr_addr_i,
  input  logic                  flush_i,
  output logic [N_REGS-1:0]     busy_o
);
  logic [N_REGS-1:0] busy_q, busy_d;

  // Addresses >= N_REGS never match a loop index, so they fall through untouched.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < N_REGS; i++) begin
      if (clr_en_i && clr_addr_i == ADDR_WIDTH'(i)) busy_d[i] = 1'b0;
      if (set_en_i && set_addr_i == ADDR_WIDTH'(i)) busy_d[i] = 1'b1;
    end
    if (flush_i) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_o = busy_q;
endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with two write ports (A: ALU, B: LSU),
// optional same-cycle forwarding and a busy scoreboard for pending B writes.
module reg_file_mp
  import riscv_defines::*;
#(
  parameter  int WORD_WIDTH = RF_WORD_WIDTH,
  parameter  int N_REGS     = RF_N_REGS,
  parameter  int N_READ     = 2,
  parameter  int BYPASS     = 1,
  localparam int ADDR_WIDTH = $clog2(N_REGS)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_READ-1:0][ADDR_WIDTH-1:0]     read_addr_i,
  output logic [N_READ-1:0][WORD_WIDTH-1:0]     read_data_o,
  output logic [N_READ-1:0]                     read_busy_o,
  input  logic                                  wa_en_i,
  input  logic [ADDR_WIDTH-1:0]                 wa_addr_i,
  input  logic [WORD_WIDTH-1:0]                 wa_data_i,
  input  logic                                  wb_en_i,
  input  logic [ADDR_WIDTH-1:0]                 wb_addr_i,
  input  logic [WORD_WIDTH-1:0]                 wb_data_i,
  input  logic                                  rsv_en_i,
  input  logic [ADDR_WIDTH-1:0]                 rsv_addr_i,
  input  logic                                  flush_i
);
  logic [WORD_WIDTH-1:0] regs [N_REGS];
  logic [N_REGS-1:0]     busy;
  logic                  wa_ok, wb_ok;

  function automatic logic in_rf(input logic [ADDR_WIDTH-1:0] a);
    return (a != '0) && (int'(a) < N_REGS);
  endfunction

  assign wa_ok = wa_en_i && in_rf(wa_addr_i);
  assign wb_ok = wb_en_i && in_rf(wb_addr_i);

  // B is written first so A lands last and wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else begin
      if (wb_ok) regs[wb_addr_i] <= wb_data_i;
      if (wa_ok) regs[wa_addr_i] <= wa_data_i;
    end
  end

  reg_scoreboard #(.N_REGS(N_REGS)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en_i   (rsv_en_i),
    .set_addr_i (rsv_addr_i),
    .clr_en_i   (wb_en_i),
    .clr_addr_i (wb_addr_i),
    .flush_i    (flush_i),
    .busy_o     (busy)
  );

  for (genvar p = 0; p < N_READ; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [WORD_WIDTH-1:0] rd;
    logic                  rb;

    assign ra = read_addr_i[p];

    // Output is gated by rst_n so forwarded write data cannot leak during reset.
    always_comb begin
      rd = '0;
      rb = 1'b0;
      if (rst_n && in_rf(ra)) begin
        rd = regs[ra];
        rb = busy[ra];
        if (BYPASS != 0) begin
          if (wb_ok && wb_addr_i == ra) rd = wb_data_i;
          if (wa_ok && wa_addr_i == ra) rd = wa_data_i;
          if (wb_en_i && wb_addr_i == ra && !(rsv_en_i && rsv_addr_i == ra)) rb = 1'b0;
        end
      end
    end

    assign read_data_o[p] = rd;
    assign read_busy_o[p] = rb;
  end
endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;
  logic clk = 1'b0;
  logic rst_n;
  logic wa_en, wb_en, rsv_en, flush;
  logic [4:0]  wa_addr, wb_addr, rsv_addr;
  logic [63:0] wa_data, wb_data;
  logic [3:0][4:0] raddr;

  logic [1:0][4:0]  a_raddr;
  logic [1:0][31:0] a_rdata;
  logic [1:0]       a_rbusy;
  logic [3:0][3:0]  b_raddr;
  logic [3:0][63:0] b_rdata;
  logic [3:0]       b_rbusy;

  always #5 clk = ~clk;

  assign a_raddr = raddr[1:0];
  always_comb for (int i = 0; i < 4; i++) b_raddr[i] = raddr[i][3:0];

  reg_file_mp #(.WORD_WIDTH(32), .N_REGS(24), .N_READ(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .read_addr_i(a_raddr), .read_data_o(a_rdata), .read_busy_o(a_rbusy),
    .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data[31:0]),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data[31:0]),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .flush_i(flush)
  );

  reg_file_mp #(.WORD_WIDTH(64), .N_REGS(16), .N_READ(4), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .read_addr_i(b_raddr), .read_data_o(b_rdata), .read_busy_o(b_rbusy),
    .wa_en_i(wa_en), .wa_addr_i(wa_addr[3:0]), .wa_data_i(wa_data),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr[3:0]), .wb_data_i(wb_data),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr[3:0]), .flush_i(flush)
  );

  typedef struct {
    int          d;
    int          p;
    logic [63:0] data;
    logic        busy;
    string       nm;
  } exp_t;

  exp_t        q[$];
  logic [63:0] mem [2][32];
  logic        bsy [2][32];
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic int nregs(input int d);
    return (d != 0) ? 16 : 24;
  endfunction

  function automatic logic [63:0] msk(input int d);
    return (d != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic int ad(input int d, input logic [4:0] a);
    return (d != 0) ? int'(a[3:0]) : int'(a);
  endfunction

  task automatic push_c(input int d, input int p, input logic [63:0] data, input logic b, input string nm);
    exp_t e;
    e.d = d; e.p = p; e.data = data; e.busy = b; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic issue(input string nm);
    for (int d = 0; d < 2; d++) begin
      int nr, wa, wb, rs, a;
      logic [63:0] m, data;
      logic b;
      nr = nregs(d); m = msk(d);
      wa = ad(d, wa_addr); wb = ad(d, wb_addr); rs = ad(d, rsv_addr);
      for (int p = 0; p < ((d != 0) ? 4 : 2); p++) begin
        a = ad(d, raddr[p]);
        data = '0; b = 1'b0;
        if (rst_n && a != 0 && a < nr) begin
          data = mem[d][a]; b = bsy[d][a];
          if (d == 0) begin
            if (wb_en && wb == a) begin
              data = wb_data & m;
              if (!(rsv_en && rs == a)) b = 1'b0;
            end
            if (wa_en && wa == a) data = wa_data & m;
          end
        end
        push_c(d, p, data, b, nm);
      end
      if (!rst_n) begin
        for (int i = 0; i < 32; i++) begin mem[d][i] = '0; bsy[d][i] = 1'b0; end
      end else begin
        if (wb_en && wb != 0 && wb < nr) mem[d][wb] = wb_data & m;
        if (wa_en && wa != 0 && wa < nr) mem[d][wa] = wa_data & m;
        if (flush) begin
          for (int i = 0; i < 32; i++) bsy[d][i] = 1'b0;
        end else begin
          if (wb_en && wb < nr) bsy[d][wb] = 1'b0;
          if (rsv_en && rs != 0 && rs < nr) bsy[d][rs] = 1'b1;
        end
      end
    end
  endtask

  task automatic idle();
    wa_en = 1'b0; wb_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  task automatic cyc(input string nm);
    issue(nm);
    @(posedge clk); #1;
    idle();
  endtask

  task automatic all_rd(input logic [4:0] a);
    for (int i = 0; i < 4; i++) raddr[i] = a;
  endtask

  function automatic logic [4:0] pick();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
  endfunction

  exp_t        e;
  logic [63:0] act_d;
  logic        act_b;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      act_d = (e.d != 0) ? b_rdata[e.p] : {32'h0, a_rdata[e.p]};
      act_b = (e.d != 0) ? b_rbusy[e.p] : a_rbusy[e.p];
      n_chk++;
      if (act_d !== e.data || act_b !== e.busy) begin
        n_fail++;
        $display("FAIL %s dut%0d port%0d: got data=%h busy=%b, want data=%h busy=%b",
                 e.nm, e.d, e.p, act_d, act_b, e.data, e.busy);
      end
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: stimulus did not complete, %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    rst_n = 1'b0; idle();
    wa_addr = '0; wb_addr = '0; rsv_addr = '0; wa_data = '0; wb_data = '0;
    all_rd(5'd0);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++) begin mem[d][i] = '0; bsy[d][i] = 1'b0; end
    @(posedge clk); #1;
    all_rd(5'd5);
    #1;
    n_chk++;
    if (a_rdata !== '0 || a_rbusy !== '0 || b_rdata !== '0 || b_rbusy !== '0) begin
      n_fail++;
      $display("FAIL reset_state: a_rdata=%h a_rbusy=%b b_rdata=%h b_rbusy=%b",
               a_rdata, a_rbusy, b_rdata, b_rbusy);
    end
    cyc("reset");
    rst_n = 1'b1;

    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 64'hDEAD_BEEF;
    push_c(0, 0, 64'hDEAD_BEEF, 1'b0, "x5_bypass");
    push_c(1, 0, 64'h0, 1'b0, "x5_no_bypass");
    cyc("x5_wr");
    push_c(0, 0, 64'hDEAD_BEEF, 1'b0, "x5_rd");
    push_c(1, 0, 64'hDEAD_BEEF, 1'b0, "x5_rd");
    cyc("x5_rd");

    all_rd(5'd0);
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = '1;
    for (int p = 0; p < 2; p++) push_c(0, p, 64'h0, 1'b0, "x0_wr");
    cyc("x0_wr");
    for (int p = 0; p < 4; p++) push_c(1, p, 64'h0, 1'b0, "x0_rd");
    cyc("x0_rd");

    all_rd(5'd7);
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 64'h11;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 64'h22;
    cyc("x7_ab");
    push_c(0, 0, 64'h11, 1'b0, "x7_a_wins");
    push_c(1, 0, 64'h11, 1'b0, "x7_a_wins");
    cyc("x7_rd");

    all_rd(5'd9);
    rsv_en = 1'b1; rsv_addr = 5'd9;
    cyc("rsv9");
    push_c(0, 0, 64'h0, 1'b1, "x9_busy");
    push_c(1, 0, 64'h0, 1'b1, "x9_busy");
    cyc("x9_busy");
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 64'h55;
    push_c(0, 0, 64'h55, 1'b0, "x9_clr_bypass");
    push_c(1, 0, 64'h0, 1'b1, "x9_clr_stored");
    cyc("x9_wb");
    push_c(0, 0, 64'h55, 1'b0, "x9_cleared");
    push_c(1, 0, 64'h55, 1'b0, "x9_cleared");
    cyc("x9_cleared");
    rsv_en = 1'b1; rsv_addr = 5'd9; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 64'h66;
    cyc("x9_rsv_wb");
    push_c(0, 0, 64'h66, 1'b1, "x9_rsv_wins");
    push_c(1, 0, 64'h66, 1'b1, "x9_rsv_wins");
    cyc("x9_rsv_wins");

    rsv_en = 1'b1; rsv_addr = 5'd3; cyc("rsv3");
    rsv_en = 1'b1; rsv_addr = 5'd4; cyc("rsv4");
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd6; cyc("flush_rsv6");
    raddr[0] = 5'd3; raddr[1] = 5'd4; raddr[2] = 5'd6; raddr[3] = 5'd9;
    push_c(0, 0, 64'h0, 1'b0, "flush_x3");
    push_c(0, 1, 64'h0, 1'b0, "flush_x4");
    push_c(1, 2, 64'h0, 1'b0, "flush_x6");
    push_c(1, 3, 64'h66, 1'b0, "flush_x9");
    cyc("flush_rd");

    all_rd(5'd5);
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 64'hAAAA_5555;
    cyc("x5_wr2");
    rst_n = 1'b0; wa_en = 1'b1; wa_addr = 5'd5; wa_data = 64'h1234;
    for (int p = 0; p < 2; p++) push_c(0, p, 64'h0, 1'b0, "rst_mid");
    for (int p = 0; p < 4; p++) push_c(1, p, 64'h0, 1'b0, "rst_mid");
    cyc("rst_mid");
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 64'h5678;
    cyc("rst_hold");
    rst_n = 1'b1;
    push_c(0, 0, 64'h0, 1'b0, "x5_after_rst");
    push_c(1, 0, 64'h0, 1'b0, "x5_after_rst");
    cyc("x5_after_rst");

    wa_en = 1'b1; wa_addr = 5'd15; wa_data = 64'h0123_4567_89AB_CDEF;
    cyc("x15_wr");
    all_rd(5'd15);
    for (int p = 0; p < 4; p++) push_c(1, p, 64'h0123_4567_89AB_CDEF, 1'b0, "x15_wide");
    for (int p = 0; p < 2; p++) push_c(0, p, 64'h89AB_CDEF, 1'b0, "x15_narrow");
    cyc("x15_rd");

    all_rd(5'd25);
    wa_en = 1'b1; wa_addr = 5'd25; wa_data = 64'h77; rsv_en = 1'b1; rsv_addr = 5'd25;
    cyc("oor_wr");
    push_c(0, 0, 64'h0, 1'b0, "oor_rd");
    push_c(0, 1, 64'h0, 1'b0, "oor_rd");
    cyc("oor_rd");

    for (int n = 0; n < 600; n++) begin
      rst_n   = ($urandom_range(0, 63) != 0);
      wa_en   = 1'($urandom_range(0, 1));
      wa_addr = pick();
      wa_data = {$urandom, $urandom};
      wb_en   = 1'($urandom_range(0, 1));
      wb_addr = ($urandom_range(0, 3) == 0) ? wa_addr : pick();
      wb_data = {$urandom, $urandom};
      rsv_en  = ($urandom_range(0, 2) == 0);
      rsv_addr = ($urandom_range(0, 2) == 0) ? wb_addr : pick();
      flush   = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < 4; i++)
        raddr[i] = ($urandom_range(0, 2) == 0) ? wa_addr :
                   (($urandom_range(0, 1) != 0) ? wb_addr : pick());
      cyc("random");
    end
    rst_n = 1'b1;
    @(negedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
